// File: rtl/mem_utils.sv
// Shared LSU memory-map definitions: timer register offsets, CTRL field layout,
// store-size encoding and byte-lane write helpers.
package mem_utils;

   localparam logic [4:0]  TMR_OFF_MTIME_LO = 5'h00;
   localparam logic [4:0]  TMR_OFF_MTIME_HI = 5'h04;
   localparam logic [4:0]  TMR_OFF_CMP_LO   = 5'h08;
   localparam logic [4:0]  TMR_OFF_CMP_HI   = 5'h0C;
   localparam logic [4:0]  TMR_OFF_CTRL     = 5'h10;
   localparam logic [4:0]  TMR_OFF_STATUS   = 5'h14;
   localparam logic [31:0] TMR_WINDOW_BYTES = 32'h0000_0020;

   localparam int CTRL_EN_BIT       = 0;
   localparam int CTRL_PRESCALE_LSB = 8;
   localparam int CTRL_PRESCALE_W   = 8;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_NONE = 2'b11
   } store_size_e;

   function automatic logic [3:0] lane_mask(input store_size_e size, input logic [1:0] byte_off);
      logic [3:0] mask;
      case (size)
         SIZE_BYTE: mask = 4'b0001 << byte_off;
         SIZE_HALF: mask = byte_off[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: mask = 4'b1111;
         default:   mask = 4'b0000;
      endcase
      return mask;
   endfunction

   // Store data arrives LSB-aligned; replicating it lets any masked lane pick it up.
   function automatic logic [31:0] lane_replicate(input store_size_e size, input logic [31:0] data);
      logic [31:0] rep;
      case (size)
         SIZE_BYTE: rep = {4{data[7:0]}};
         SIZE_HALF: rep = {2{data[15:0]}};
         default:   rep = data;
      endcase
      return rep;
   endfunction

   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit machine timer with compare interrupt on the LSU bus.
// Reading MTIME_LO snapshots the upper half so LO-then-HI reads stay coherent.
module mmio_timer
   import mem_utils::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write_en,
   input  logic        read_en,
   input  logic [31:0] addr,
   input  logic [1:0]  store_size,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        timer_irq
);

   logic [63:0]                mtime_q, mtime_d;
   logic [63:0]                mtimecmp_q, mtimecmp_d;
   logic                       en_q, en_d;
   logic [CTRL_PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [CTRL_PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [31:0]                hi_shadow_q, hi_shadow_d;
   logic [31:0]                read_data_q, read_data_d;
   logic                       irq_q, irq_d;

   logic [31:0] offset;
   logic        in_window;
   logic        wr_hit;
   logic        rd_hit;
   logic [4:0]  reg_sel;
   logic [3:0]  wr_mask;
   logic [31:0] wr_rep;
   logic [31:0] ctrl_word;
   logic        irq_cond;

   assign offset    = addr - BASE_ADDR;
   assign in_window = offset < TMR_WINDOW_BYTES;
   assign reg_sel   = {offset[4:2], 2'b00};
   assign wr_mask   = lane_mask(store_size_e'(store_size), addr[1:0]);
   assign wr_rep    = lane_replicate(store_size_e'(store_size), write_data);
   assign wr_hit    = write_en && in_window && (wr_mask != 4'b0000);
   assign rd_hit    = read_en && in_window;
   assign irq_cond  = en_q && (mtime_q >= mtimecmp_q);

   always_comb begin
      ctrl_word = '0;
      ctrl_word[CTRL_EN_BIT] = en_q;
      ctrl_word[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W] = prescale_q;
   end

   always_comb begin
      mtime_d     = mtime_q;
      mtimecmp_d  = mtimecmp_q;
      en_d        = en_q;
      prescale_d  = prescale_q;
      pre_cnt_d   = pre_cnt_q;
      hi_shadow_d = hi_shadow_q;
      read_data_d = read_data_q;
      irq_d       = irq_cond;

      if (en_q) begin
         if (pre_cnt_q == prescale_q) begin
            pre_cnt_d = '0;
            mtime_d   = mtime_q + 64'd1;
         end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
         end
      end

      // A software write to either mtime half replaces that half outright and
      // leaves the other half as it was, so this cycle's increment is lost.
      if (wr_hit) begin
         case (reg_sel)
            TMR_OFF_MTIME_LO: mtime_d    = {mtime_q[63:32], lane_merge(mtime_q[31:0], wr_rep, wr_mask)};
            TMR_OFF_MTIME_HI: mtime_d    = {lane_merge(mtime_q[63:32], wr_rep, wr_mask), mtime_q[31:0]};
            TMR_OFF_CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], lane_merge(mtimecmp_q[31:0], wr_rep, wr_mask)};
            TMR_OFF_CMP_HI:   mtimecmp_d = {lane_merge(mtimecmp_q[63:32], wr_rep, wr_mask), mtimecmp_q[31:0]};
            TMR_OFF_CTRL: begin
               if (wr_mask[CTRL_EN_BIT / 8])       en_d       = wr_rep[CTRL_EN_BIT];
               if (wr_mask[CTRL_PRESCALE_LSB / 8]) prescale_d = wr_rep[CTRL_PRESCALE_LSB +: CTRL_PRESCALE_W];
               pre_cnt_d = '0;
            end
            default: ;
         endcase
      end

      if (rd_hit) begin
         case (reg_sel)
            TMR_OFF_MTIME_LO: begin
               read_data_d = mtime_q[31:0];
               hi_shadow_d = mtime_q[63:32];
            end
            TMR_OFF_MTIME_HI: read_data_d = hi_shadow_q;
            TMR_OFF_CMP_LO:   read_data_d = mtimecmp_q[31:0];
            TMR_OFF_CMP_HI:   read_data_d = mtimecmp_q[63:32];
            TMR_OFF_CTRL:     read_data_d = ctrl_word;
            TMR_OFF_STATUS:   read_data_d = {31'b0, irq_cond};
            default:          read_data_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q     <= '0;
         mtimecmp_q  <= '1;
         en_q        <= 1'b0;
         prescale_q  <= '0;
         pre_cnt_q   <= '0;
         hi_shadow_q <= '0;
         read_data_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         en_q        <= en_d;
         prescale_q  <= prescale_d;
         pre_cnt_q   <= pre_cnt_d;
         hi_shadow_q <= hi_shadow_d;
         read_data_q <= read_data_d;
         irq_q       <= irq_d;
      end
   end

   assign read_data = read_data_q;
   assign timer_irq = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: reads push expected data into a scoreboard
// queue that is popped and compared once read_data has been registered.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [4:0]  MLO = 5'h00, MHI = 5'h04, CLO = 5'h08, CHI = 5'h0C;
   localparam logic [4:0]  CTL = 5'h10, STS = 5'h14, UNM = 5'h18;

   logic        clk;
   logic        rst;
   logic        write_en;
   logic        read_en;
   logic [31:0] addr;
   logic [1:0]  store_size;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        timer_irq;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_data[$];
   string       exp_tag[$];

   mmio_timer #(.BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .rst        (rst),
      .write_en   (write_en),
      .read_en    (read_en),
      .addr       (addr),
      .store_size (store_size),
      .write_data (write_data),
      .read_data  (read_data),
      .timer_irq  (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic we, input logic re, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [31:0] exp, input string tag);
      write_en   = we;
      read_en    = re;
      addr       = a;
      store_size = sz;
      write_data = wd;
      if (re) begin
         exp_data.push_back(exp);
         exp_tag.push_back(tag);
      end
      @(posedge clk);
      #1;
      write_en = 1'b0;
      read_en  = 1'b0;
      $display("txn we=%0b re=%0b addr=%08h sz=%0d wd=%08h rd=%08h irq=%0b",
               we, re, a, sz, wd, read_data, timer_irq);
      while (exp_data.size() > 0) check(exp_tag.pop_front(), read_data, exp_data.pop_front());
   endtask

   task automatic wr(input logic [4:0] off, input logic [31:0] d);
      access(1'b1, 1'b0, BASE + {27'b0, off}, 2'b10, d, 32'h0, "");
   endtask

   task automatic rd(input logic [4:0] off, input logic [31:0] e, input string tag);
      access(1'b0, 1'b1, BASE + {27'b0, off}, 2'b10, 32'h0, e, tag);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; write_en = 1'b0; read_en = 1'b0;
      addr = '0; store_size = 2'b10; write_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_read_data", read_data, 32'h0);
      check("rst_irq", {31'b0, timer_irq}, 32'h0);
      rd(MLO, 32'h0, "rst_mtime_lo");
      rd(MHI, 32'h0, "rst_mtime_hi");
      rd(CLO, 32'hFFFF_FFFF, "rst_cmp_lo");
      rd(CHI, 32'hFFFF_FFFF, "rst_cmp_hi");
      rd(UNM, 32'h0, "unmapped_read");
      rd(CTL, 32'h0, "rst_ctrl");
      rd(STS, 32'h0, "rst_status");
      rd(CLO, 32'hFFFF_FFFF, "cmp_lo_again");
      access(1'b0, 1'b1, BASE + 32'h20, 2'b10, 32'h0, 32'hFFFF_FFFF, "oow_above_holds");
      access(1'b0, 1'b1, BASE - 32'h4, 2'b10, 32'h0, 32'hFFFF_FFFF, "oow_below_holds");

      // EN with prescale 0: one tick per cycle
      wr(CTL, 32'h0000_0001);
      idle(10);
      rd(MLO, 32'd10, "count_10_cycles");
      rd(MHI, 32'd0, "count_10_hi");

      // prescale 3: one tick every 4 cycles
      wr(CTL, 32'h0);
      wr(MLO, 32'h0);
      wr(MHI, 32'h0);
      wr(CTL, 32'h0000_0301);
      idle(6);
      rd(MLO, 32'd1, "prescale_6_cycles");
      idle(33);
      rd(MLO, 32'd10, "prescale_40_cycles");
      wr(CTL, 32'h0000_0300);
      idle(5);
      rd(MLO, 32'd10, "frozen_when_disabled");
      rd(CTL, 32'h0000_0300, "ctrl_readback");

      // single increment carries into the upper half
      wr(MLO, 32'hFFFF_FFFF);
      wr(MHI, 32'h0);
      wr(CTL, 32'h0000_0001);
      wr(CTL, 32'h0);
      rd(MLO, 32'h0, "carry_lo");
      rd(MHI, 32'h1, "carry_hi");

      // LO then HI stays coherent across an increment in between
      wr(MLO, 32'hFFFF_FFFF);
      wr(MHI, 32'h0);
      wr(CTL, 32'h0000_0001);
      rd(MLO, 32'hFFFF_FFFF, "coherent_lo");
      rd(MHI, 32'h0, "coherent_hi_shadow");
      rd(MLO, 32'h1, "coherent_lo_2");
      rd(MHI, 32'h1, "coherent_hi_2");
      wr(CTL, 32'h0);

      // full 64-bit wrap; mtime == mtimecmp also satisfies the compare
      wr(MLO, 32'hFFFF_FFFF);
      wr(MHI, 32'hFFFF_FFFF);
      wr(CTL, 32'h0000_0001);
      wr(CTL, 32'h0);
      check("irq_on_equal", {31'b0, timer_irq}, 32'h1);
      idle(1);
      check("irq_drops_on_disable", {31'b0, timer_irq}, 32'h0);
      rd(MLO, 32'h0, "wrap_lo");
      rd(MHI, 32'h0, "wrap_hi");

      // write beats the same-cycle increment
      wr(CTL, 32'h0000_0001);
      wr(MLO, 32'h0000_0050);
      wr(CTL, 32'h0);
      rd(MLO, 32'h0000_0051, "write_priority_lo");
      rd(MHI, 32'h0, "write_priority_hi");

      // compare interrupt rise and fall
      wr(MLO, 32'h0);
      wr(MHI, 32'h0);
      wr(CLO, 32'd20);
      wr(CHI, 32'h0);
      check("irq_idle_low", {31'b0, timer_irq}, 32'h0);
      wr(CTL, 32'h0000_0001);
      idle(20);
      check("irq_before_match", {31'b0, timer_irq}, 32'h0);
      idle(1);
      check("irq_after_match", {31'b0, timer_irq}, 32'h1);
      rd(STS, 32'h1, "status_irq_set");
      check("irq_no_clear_on_read", {31'b0, timer_irq}, 32'h1);
      wr(CLO, 32'd100);
      check("irq_still_registered", {31'b0, timer_irq}, 32'h1);
      idle(1);
      check("irq_falls_after_cmp_write", {31'b0, timer_irq}, 32'h0);
      rd(STS, 32'h0, "status_irq_clear");
      wr(CTL, 32'h0);

      // byte/half lane stores, ignored size, dropped writes
      access(1'b1, 1'b0, BASE + 32'h09, 2'b00, 32'h1234_56AB, 32'h0, "");
      rd(CLO, 32'h0000_AB64, "byte_store_cmp_lo");
      rd(CHI, 32'h0, "byte_store_cmp_hi");
      access(1'b1, 1'b0, BASE + 32'h08, 2'b11, 32'hDEAD_BEEF, 32'h0, "");
      rd(CLO, 32'h0000_AB64, "size11_no_write");
      access(1'b1, 1'b0, BASE + 32'h0E, 2'b01, 32'hFFFF_1234, 32'h0, "");
      rd(CHI, 32'h1234_0000, "half_store_cmp_hi");
      access(1'b1, 1'b0, BASE + 32'h11, 2'b00, 32'h0000_0005, 32'h0, "");
      rd(CTL, 32'h0000_0500, "byte_store_ctrl");
      wr(MLO, 32'h0000_0055);
      access(1'b1, 1'b0, BASE + 32'h20, 2'b10, 32'hAAAA_AAAA, 32'h0, "");
      access(1'b1, 1'b0, BASE - 32'h4, 2'b10, 32'hBBBB_BBBB, 32'h0, "");
      wr(UNM, 32'hCCCC_CCCC);
      rd(MLO, 32'h0000_0055, "oow_write_dropped");
      rd(UNM, 32'h0, "unmapped_write_dropped");

      // read and write of the same register in one cycle
      access(1'b1, 1'b1, BASE, 2'b10, 32'h0000_0077, 32'h0000_0055, "rw_same_cycle_old");
      rd(MLO, 32'h0000_0077, "rw_same_cycle_new");

      // reset mid-count with irq high, alongside a write and a read
      wr(CLO, 32'h0);
      wr(CHI, 32'h0);
      wr(CTL, 32'h0000_0201);
      idle(3);
      check("irq_high_pre_reset", {31'b0, timer_irq}, 32'h1);
      rd(CTL, 32'h0000_0201, "ctrl_pre_reset");
      rst = 1'b1; write_en = 1'b1; read_en = 1'b1;
      addr = BASE; store_size = 2'b10; write_data = 32'h0000_0099;
      @(posedge clk);
      #1;
      rst = 1'b0; write_en = 1'b0; read_en = 1'b0;
      check("reset_read_data", read_data, 32'h0);
      check("reset_irq", {31'b0, timer_irq}, 32'h0);
      rd(MLO, 32'h0, "reset_mtime_lo");
      rd(MHI, 32'h0, "reset_mtime_hi");
      rd(CLO, 32'hFFFF_FFFF, "reset_cmp_lo");
      rd(CHI, 32'hFFFF_FFFF, "reset_cmp_hi");
      rd(CTL, 32'h0, "reset_ctrl");
      idle(3);
      rd(MLO, 32'h0, "reset_stays_frozen");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
